cart_loader: RTL and testbench
==============================

# cart_loader

Boot and program-select sequencer for the CHIP-8 core. It holds the CPU off the shared RAM and VRAM ports and copies the selected program bank out of the multi-bank program ROM into RAM at the program base. It then optionally clears VRAM and releases the CPU. It re-runs on a `start` pulse, so the player can swap games without a full reset.

## Interface
Parameters:
- `PROG_BASE`, default 12'h200: RAM byte address of the first program byte.
- `PROG_BYTES`, default 3584: number of bytes copied. `PROG_BASE + PROG_BYTES` must be ≤ 4096.
- `BANK_BITS`, default 4: ROM bank select width (16 banks of 4 KiB).

Ports:
- `clk`, in, 1: single system clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request to reload; sampled only in RUN.
- `bank`, in, BANK_BITS: program bank to load; latched in START.
- `rom_addr`, out, BANK_BITS+12: `{bank_q, byte address}` to the synchronous program ROM.
- `rom_dout`, in, 8: ROM data, valid one cycle after `rom_addr`.
- `ram_addr`, out, 12: RAM write address.
- `ram_din`, out, 8: RAM write data.
- `ram_we`, out, 1: RAM write strobe.
- `vram_hpos`, out, 7: VRAM clear column.
- `vram_vpos`, out, 6: VRAM clear row.
- `vram_pixeli`, out, 2: always 2'b00.
- `vram_we`, out, 1: VRAM write strobe.
- `busy`, out, 1: high while the loader owns RAM/VRAM; the top level muxes ports on it.
- `cpu_run`, out, 1: CPU enable. The CPU must hold its PC and timers while low.
- `done`, out, 1: one-cycle pulse on entry to RUN.

## Operation
States: START → COPY → CLEAR → RUN.

- **Reset** (async, while `reset`=0):
  - State START; all counters 0; `bank_q`=0.
  - Outputs: `busy`=1, `cpu_run`=0, `done`=0, `ram_we`=0, `vram_we`=0, all addresses 0.
- **START** (1 cycle): latch `bank_q <= bank`; clear the byte counter `k`; go to COPY.
- **COPY** (two-stage pipeline, ROM read latency 1):
  - Read stage: for `k` = 0..PROG_BYTES-1, `rom_addr = {bank_q, PROG_BASE+k}`.
  - Write stage, one cycle later: `ram_we`=1, `ram_addr = PROG_BASE+k-1`, `ram_din = rom_dout`.
  - The last write occurs in the cycle after the last read, so COPY lasts PROG_BYTES+1 cycles.
  - Exit to CLEAR, or to RUN if the clear phase is compiled out.
- **CLEAR**:
  - `vram_we`=1 and `vram_pixeli`=0 every cycle.
  - Sweep order: `vram_hpos` 0..127 inner loop, `vram_vpos` 0..63 outer loop; 8192 cycles.
  - The write of (127,63) is the last CLEAR cycle; next state is RUN.
- **RUN**:
  - `busy`=0, `cpu_run`=1, all write strobes 0.
  - `done`=1 only in the first RUN cycle.
  - `start`=1 → START on the next edge; `cpu_run` drops on that same edge.
- `start` is ignored in START, COPY and CLEAR; a pending request is not queued.
- Reset mid-COPY or mid-CLEAR aborts immediately with no further writes. The sequence restarts from START after `reset` returns high.
- Address arithmetic is 12-bit unsigned. With the default parameters the last address is 12'hFFF and no wrap occurs.

## Timing
- `rom_addr` is registered. `ram_addr`/`ram_din`/`ram_we` are registered from the previous read cycle.
- Latency from the first rising edge after reset release to `cpu_run`=1:
  - with clear: 1 + (PROG_BYTES+1) + 8192 cycles = 11778 at default parameters;
  - without clear: 3586 cycles.
- From `start` sampled in RUN, the same latency applies, measured from that edge.
- `busy` is exactly the complement of `cpu_run` at every cycle.

## Configuration
- `LOADER_VRAM_CLEAR_EN` defined: the CLEAR state exists and VRAM is zeroed before every run.
- `LOADER_VRAM_CLEAR_EN` undefined: CLEAR is removed and COPY exits directly to RUN. `vram_we` is tied 0 and `vram_hpos`/`vram_vpos` are tied 0.

## Test plan
- **Reset/boot:** release `reset` with `bank`=3, ROM bank 3 holding byte = low 8 bits of address.
  - RAM[0x200..0xFFF] must equal ROM[0x3200..0x3FFF].
  - `cpu_run` rises after 11778 edges with clear in, 3586 with clear out.
  - `done` pulses exactly once.
- **Pipeline alignment:** check the first and last writes.
  - First write: `ram_addr`=0x200 with the data from `rom_addr`=0x3200, one cycle later.
  - Last write: `ram_addr`=0xFFF.
  - No RAM write outside 0x200..0xFFF.
- **VRAM clear:** preload VRAM with 2'b11 everywhere.
  - After the load, all 8192 pixels read 0.
  - `vram_we` is high for exactly 8192 cycles.
- **Reload:** in RUN, set `bank`=5 and pulse `start`.
  - `cpu_run` drops on the next edge.
  - RAM ends with bank 5 contents; `done` pulses again.
- **Ignored start:** pulse `start` mid-COPY with `bank` changed.
  - The load completes with the originally latched bank.
  - Exactly one `done` pulse.
- **Reset mid-operation:** assert `reset` during CLEAR at vpos=10.
  - Strobes go low asynchronously; `cpu_run`=0.
  - After release, a full load restarts from START.

Source files
------------

// File: rtl/cart_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cart_loader
//  Purpose  : Boot / program-select sequencer for the CHIP-8 core. While busy
//             it owns the RAM and VRAM ports. It copies the selected program
//             ROM bank into RAM at PROG_BASE, optionally clears VRAM, and then
//             releases the CPU. A start pulse in RUN reloads without a reset.
//  Config   : LOADER_VRAM_CLEAR_EN - when defined, the CLEAR state zeroes all
//             128x64 VRAM pixels after every copy. When undefined, COPY goes
//             straight to RUN and the VRAM outputs are tied to 0.
//  Ports    : clk_i          system clock, rising edge
//             reset_ni       asynchronous active-low reset
//             start_i        reload request, sampled only in RUN
//             bank_i         program bank, latched in START
//             rom_addr_o     {bank, byte address} to the synchronous ROM
//             rom_dout_i     ROM data, one cycle after rom_addr_o
//             ram_addr_o     RAM write address
//             ram_din_o      RAM write data
//             ram_we_o       RAM write strobe
//             vram_hpos_o    VRAM clear column
//             vram_vpos_o    VRAM clear row
//             vram_pixeli_o  VRAM write data, always 0
//             vram_we_o      VRAM write strobe
//             busy_o         loader owns RAM/VRAM
//             cpu_run_o      CPU enable, the complement of busy_o
//             done_o         one-cycle pulse in the first RUN cycle
//  Revision : 1.0 - initial release
// ============================================================================
module cart_loader #(
   parameter logic [11:0] PROG_BASE  = 12'h200,
   parameter int unsigned PROG_BYTES = 3584,
   parameter int unsigned BANK_BITS  = 4
) (
   input  logic                    clk_i,
   input  logic                    reset_ni,
   input  logic                    start_i,
   input  logic [BANK_BITS-1:0]    bank_i,
   output logic [BANK_BITS+11:0]   rom_addr_o,
   input  logic [7:0]              rom_dout_i,
   output logic [11:0]             ram_addr_o,
   output logic [7:0]              ram_din_o,
   output logic                    ram_we_o,
   output logic [6:0]              vram_hpos_o,
   output logic [5:0]              vram_vpos_o,
   output logic [1:0]              vram_pixeli_o,
   output logic                    vram_we_o,
   output logic                    busy_o,
   output logic                    cpu_run_o,
   output logic                    done_o
);

   // COPY runs k = 0..PROG_BYTES: reads for k < PROG_BYTES, writes trail by one.
   localparam logic [12:0] C_LAST_K  = 13'(PROG_BYTES);
   localparam logic [12:0] C_LAST_RD = 13'(PROG_BYTES - 1);

   typedef enum logic [1:0] {
      S_START = 2'd0,
      S_COPY  = 2'd1,
`ifdef LOADER_VRAM_CLEAR_EN
      S_CLEAR = 2'd2,
`endif
      S_RUN   = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [BANK_BITS-1:0]    bank_q, bank_d;
   logic [12:0]             k_q, k_d;
   logic [BANK_BITS+11:0]   rom_addr_q, rom_addr_d;
   logic [11:0]             ram_addr_q, ram_addr_d;
   logic                    ram_we_q, ram_we_d;
   logic                    done_q, done_d;
`ifdef LOADER_VRAM_CLEAR_EN
   // Pixel index {vpos, hpos}: hpos is the inner loop.
   logic [12:0]             pix_q, pix_d;
`endif

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= S_START;
         bank_q     <= '0;
         k_q        <= '0;
         rom_addr_q <= '0;
         ram_addr_q <= '0;
         ram_we_q   <= 1'b0;
         done_q     <= 1'b0;
`ifdef LOADER_VRAM_CLEAR_EN
         pix_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         bank_q     <= bank_d;
         k_q        <= k_d;
         rom_addr_q <= rom_addr_d;
         ram_addr_q <= ram_addr_d;
         ram_we_q   <= ram_we_d;
         done_q     <= done_d;
`ifdef LOADER_VRAM_CLEAR_EN
         pix_q      <= pix_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      bank_d     = bank_q;
      k_d        = k_q;
      rom_addr_d = '0;
      ram_addr_d = '0;
      ram_we_d   = 1'b0;
      done_d     = 1'b0;
`ifdef LOADER_VRAM_CLEAR_EN
      pix_d      = pix_q;
`endif
      case (state_q)
         S_START: begin
            bank_d     = bank_i;
            k_d        = '0;
            // Present the first read address in COPY cycle 0.
            rom_addr_d = {bank_i, PROG_BASE};
            state_d    = S_COPY;
         end
         S_COPY: begin
            // Byte k is read this cycle; its write is issued next cycle.
            if (k_q < C_LAST_K) begin
               ram_we_d   = 1'b1;
               ram_addr_d = PROG_BASE + k_q[11:0];
            end
            if (k_q < C_LAST_RD) begin
               rom_addr_d = {bank_q, PROG_BASE + k_q[11:0] + 12'd1};
            end
            if (k_q == C_LAST_K) begin
               k_d     = '0;
`ifdef LOADER_VRAM_CLEAR_EN
               pix_d   = '0;
               state_d = S_CLEAR;
`else
               done_d  = 1'b1;
               state_d = S_RUN;
`endif
            end else begin
               k_d = k_q + 13'd1;
            end
         end
`ifdef LOADER_VRAM_CLEAR_EN
         S_CLEAR: begin
            if (pix_q == '1) begin
               pix_d   = '0;
               done_d  = 1'b1;
               state_d = S_RUN;
            end else begin
               pix_d = pix_q + 13'd1;
            end
         end
`endif
         S_RUN: begin
            if (start_i) begin
               state_d = S_START;
            end
         end
         default: begin
            state_d = S_START;
         end
      endcase
   end

   assign rom_addr_o    = rom_addr_q;
   assign ram_addr_o    = ram_addr_q;
   assign ram_we_o      = ram_we_q;
   // The ROM output register already provides the pipeline stage for data.
   assign ram_din_o     = ram_we_q ? rom_dout_i : 8'h00;
   assign vram_pixeli_o = 2'b00;
   assign cpu_run_o     = (state_q == S_RUN);
   assign busy_o        = (state_q != S_RUN);
   assign done_o        = done_q;

`ifdef LOADER_VRAM_CLEAR_EN
   assign vram_we_o     = (state_q == S_CLEAR);
   assign vram_hpos_o   = pix_q[6:0];
   assign vram_vpos_o   = pix_q[12:7];
`else
   assign vram_we_o     = 1'b0;
   assign vram_hpos_o   = 7'd0;
   assign vram_vpos_o   = 6'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cart_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_cart_loader
//  Purpose  : Self-checking bench for cart_loader. Behavioural ROM/RAM/VRAM
//             models; expected RAM image is the selected ROM bank slice.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cart_loader;

   localparam logic [11:0] PROG_BASE  = 12'h200;
   localparam int          PROG_BYTES = 3584;
`ifdef LOADER_VRAM_CLEAR_EN
   localparam int          CLR_CYC    = 8192;
`else
   localparam int          CLR_CYC    = 0;
`endif
   localparam int          LAT        = 1 + (PROG_BYTES + 1) + CLR_CYC;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b0;
   logic        start   = 1'b0;
   logic [3:0]  bank    = 4'd3;
   logic [15:0] rom_addr;
   logic [7:0]  rom_dout = 8'h00;
   logic [11:0] ram_addr;
   logic [7:0]  ram_din;
   logic        ram_we;
   logic [6:0]  vram_hpos;
   logic [5:0]  vram_vpos;
   logic [1:0]  vram_pixeli;
   logic        vram_we;
   logic        busy;
   logic        cpu_run;
   logic        done;

   int vectors     = 0;
   int miscompares = 0;

   cart_loader dut (
      .clk_i         (clk),
      .reset_ni      (reset_n),
      .start_i       (start),
      .bank_i        (bank),
      .rom_addr_o    (rom_addr),
      .rom_dout_i    (rom_dout),
      .ram_addr_o    (ram_addr),
      .ram_din_o     (ram_din),
      .ram_we_o      (ram_we),
      .vram_hpos_o   (vram_hpos),
      .vram_vpos_o   (vram_vpos),
      .vram_pixeli_o (vram_pixeli),
      .vram_we_o     (vram_we),
      .busy_o        (busy),
      .cpu_run_o     (cpu_run),
      .done_o        (done)
   );

   always #5 clk = ~clk;

   // Memory models
   logic [7:0] rom  [65536];
   logic [7:0] ram  [4096];
   logic [1:0] vram [8192];
   logic       vram_fill = 1'b0;
   int wr_cnt = 0, bad_cnt = 0, vwe_cnt = 0, done_cnt = 0, busy_bad = 0;

   always @(posedge clk) rom_dout <= rom[rom_addr];

   always @(posedge clk) begin
      if (ram_we) begin
         ram[ram_addr] <= ram_din;
         wr_cnt <= wr_cnt + 1;
         if (ram_addr < PROG_BASE) bad_cnt <= bad_cnt + 1;
      end
   end

   always @(posedge clk) begin
      if (vram_fill) begin
         for (int i = 0; i < 8192; i++) vram[i] <= 2'b11;
      end else if (vram_we) begin
         vram[{vram_vpos, vram_hpos}] <= vram_pixeli;
      end
      if (vram_we) vwe_cnt <= vwe_cnt + 1;
   end

   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (busy === cpu_run) busy_bad <= busy_bad + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input logic [3:0] b, input string tag);
      @(negedge clk);
      bank  = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({tag, " cpu_run drop"}, {31'd0, cpu_run}, 32'd0);
      chk({tag, " busy rise"},    {31'd0, busy},    32'd1);
   endtask

   // Waits for cpu_run from the edge that starts the sequence, then checks
   // latency, pipeline alignment, RAM image, strobe counts and done pulse.
   task automatic run_load(input logic [3:0] exp_bank, input bit mid_start,
                           input logic [3:0] mid_bank, input string tag);
      int n, d0, w0, v0, b0, errs;
      d0 = done_cnt; w0 = wr_cnt; v0 = vwe_cnt; b0 = bad_cnt;
      n  = 0;
      while (cpu_run !== 1'b1 && n < LAT + 64) begin
         @(posedge clk);
         n++;
         #1;
         if (n == 1)
            chk({tag, " first rom_addr"}, {16'd0, rom_addr}, {16'd0, exp_bank, PROG_BASE});
         if (n == 2) begin
            chk({tag, " first ram_we"},   {31'd0, ram_we}, 32'd1);
            chk({tag, " first ram_addr"}, {20'd0, ram_addr}, {20'd0, PROG_BASE});
            chk({tag, " first ram_din"},  {24'd0, ram_din}, {24'd0, rom[{exp_bank, PROG_BASE}]});
         end
         if (n == PROG_BYTES + 1) begin
            chk({tag, " last ram_we"},   {31'd0, ram_we}, 32'd1);
            chk({tag, " last ram_addr"}, {20'd0, ram_addr}, 32'h0FFF);
         end
         if (mid_start && n == 100) begin
            bank  = mid_bank;
            start = 1'b1;
         end
         if (mid_start && n == 101) start = 1'b0;
      end
      chk({tag, " latency"}, n, LAT);
      chk({tag, " done first cycle"}, {31'd0, done}, 32'd1);
      errs = 0;
      for (int i = 0; i < PROG_BYTES; i++)
         if (ram[12'(PROG_BASE + i)] !== rom[{exp_bank, 12'(PROG_BASE + i)}]) errs++;
      chk({tag, " ram image errors"}, errs, 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      chk({tag, " done one cycle"}, {31'd0, done}, 32'd0);
      chk({tag, " done pulses"},    done_cnt - d0, 1);
      chk({tag, " ram writes"},     wr_cnt - w0, PROG_BYTES);
      chk({tag, " bad writes"},     bad_cnt - b0, 0);
      chk({tag, " vram_we cycles"}, vwe_cnt - v0, CLR_CYC);
`ifdef LOADER_VRAM_CLEAR_EN
      errs = 0;
      for (int i = 0; i < 8192; i++) if (vram[i] !== 2'b00) errs++;
      chk({tag, " vram nonzero"}, errs, 0);
`endif
      chk({tag, " busy complement"}, busy_bad, 0);
   endtask

   logic [3:0] b1, b_mid, b_rst;
   int         n, found;

   initial begin
      for (int a = 0; a < 65536; a++)
         rom[a] = (a[15:12] == 4'd3) ? a[7:0] : 8'($urandom);
      b1    = 4'($urandom_range(6, 15));
      b_mid = 4'($urandom_range(0, 4));
      b_rst = 4'($urandom_range(0, 2));

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst busy",     {31'd0, busy},    32'd1);
      chk("rst cpu_run",  {31'd0, cpu_run}, 32'd0);
      chk("rst done",     {31'd0, done},    32'd0);
      chk("rst ram_we",   {31'd0, ram_we},  32'd0);
      chk("rst vram_we",  {31'd0, vram_we}, 32'd0);
      chk("rst rom_addr", {16'd0, rom_addr}, 32'd0);
      chk("rst ram_addr", {20'd0, ram_addr}, 32'd0);
      chk("rst vram pos", {19'd0, vram_vpos, vram_hpos}, 32'd0);
      chk("rst pixeli",   {30'd0, vram_pixeli}, 32'd0);
      vram_fill = 1'b1;
      @(negedge clk);
      vram_fill = 1'b0;
      @(negedge clk);

      // Boot with bank 3
      bank    = 4'd3;
      reset_n = 1'b1;
      run_load(4'd3, 1'b0, 4'd0, "boot");

      // Reload bank 5
      @(negedge clk);
      vram_fill = 1'b1;
      @(negedge clk);
      vram_fill = 1'b0;
      pulse_start(4'd5, "reload");
      run_load(4'd5, 1'b0, 4'd0, "reload");

      // Start pulsed mid-COPY with a different bank must be ignored
      pulse_start(b1, "ignore");
      run_load(b1, 1'b1, b_mid, "ignore");

      // Reset in the middle of the sequence
      pulse_start(4'd3, "abort");
      n = 0; found = 0;
      while (found == 0 && n < LAT + 64) begin
         @(posedge clk);
         n++;
         #1;
`ifdef LOADER_VRAM_CLEAR_EN
         if (vram_we && vram_vpos == 6'd10) found = 1;
`else
         if (ram_we && ram_addr == 12'h400) found = 1;
`endif
      end
      chk("abort point reached", found, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("abort ram_we",  {31'd0, ram_we},  32'd0);
      chk("abort vram_we", {31'd0, vram_we}, 32'd0);
      chk("abort cpu_run", {31'd0, cpu_run}, 32'd0);
      chk("abort busy",    {31'd0, busy},    32'd1);
      @(negedge clk);
      bank      = b_rst;
      vram_fill = 1'b1;
      @(negedge clk);
      vram_fill = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      run_load(b_rst, 1'b0, 4'd0, "restart");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
